// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: drives loads/stores on a req/ack data port and stalls upstream while waiting.
// Optional build macro MEM_ALIGN_CHECK_EN rejects word-misaligned memory ops without issuing a request.
module mem_wb_stage #(
    parameter int unsigned S       = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_valid,
    input  logic [S-1:0] mem_ALUout,
    input  logic [1:0]   mem_zero,
    input  logic [S-1:0] mem_wdata,
    input  logic         mem_memread,
    input  logic         mem_memwrite,
    input  logic         mem_regwrite,
    input  logic         mem_memtoreg,
    input  logic [4:0]   mem_rd,
    output logic         dm_req,
    output logic         dm_we,
    output logic [S-1:0] dm_addr,
    output logic [S-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [S-1:0] dm_rdata,
    output logic         stall,
    output logic         wb_valid,
    output logic         wb_regwrite,
    output logic [4:0]   wb_rd,
    output logic [S-1:0] wb_data,
    output logic [1:0]   wb_zero,
    output logic         wb_err
);

    localparam int unsigned CW = 8;

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     lat_rd_q, lat_rd_d;
    logic           lat_regwrite_q, lat_regwrite_d;
    logic           lat_memtoreg_q, lat_memtoreg_d;
    logic           lat_store_q, lat_store_d;
    logic [1:0]     lat_zero_q, lat_zero_d;

    logic           dm_req_d, dm_we_d;
    logic [S-1:0]   dm_addr_d, dm_wdata_d;
    logic           wb_valid_d, wb_regwrite_d, wb_err_d;
    logic [4:0]     wb_rd_d;
    logic [S-1:0]   wb_data_d;
    logic [1:0]     wb_zero_d;

    logic           memop_c, misalign_c, issue_c, timeout_c;

    assign memop_c = mem_valid & (mem_memread | mem_memwrite);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = memop_c & (mem_ALUout[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    assign issue_c   = (state_q == IDLE) & memop_c & ~misalign_c;
    assign timeout_c = (state_q == ACCESS) & ~dm_ack & (cnt_q == CW'(TIMEOUT - 1));

    // Upstream waits during issue and every non-final ACCESS cycle; never while in reset.
    assign stall = reset & (issue_c | ((state_q == ACCESS) & ~dm_ack & ~timeout_c));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_c) state_d = ACCESS;
            ACCESS:  if (dm_ack || timeout_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d          = '0;
        lat_rd_d       = lat_rd_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_memtoreg_d = lat_memtoreg_q;
        lat_store_d    = lat_store_q;
        lat_zero_d     = lat_zero_q;
        dm_req_d       = dm_req;
        dm_we_d        = dm_we;
        dm_addr_d      = dm_addr;
        dm_wdata_d     = dm_wdata;
        wb_valid_d     = 1'b0;
        wb_regwrite_d  = 1'b0;
        wb_rd_d        = wb_rd;
        wb_data_d      = wb_data;
        wb_zero_d      = wb_zero;
        wb_err_d       = wb_err;
        case (state_q)
            IDLE: begin
                if (misalign_c) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                    wb_rd_d    = mem_rd;
                end else if (memop_c) begin
                    dm_req_d       = 1'b1;
                    dm_we_d        = mem_memwrite;
                    dm_addr_d      = mem_ALUout;
                    dm_wdata_d     = mem_wdata;
                    lat_rd_d       = mem_rd;
                    lat_regwrite_d = mem_regwrite;
                    lat_memtoreg_d = mem_memtoreg;
                    lat_store_d    = mem_memwrite;
                    lat_zero_d     = mem_zero;
                end else if (mem_valid) begin
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = mem_regwrite;
                    wb_rd_d       = mem_rd;
                    wb_data_d     = mem_ALUout;
                    wb_zero_d     = mem_zero;
                    wb_err_d      = 1'b0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (dm_ack) begin
                    cnt_d         = '0;
                    dm_req_d      = 1'b0;
                    dm_we_d       = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = lat_store_q ? 1'b0 : lat_regwrite_q;
                    wb_rd_d       = lat_rd_q;
                    wb_data_d     = (!lat_store_q && lat_memtoreg_q) ? dm_rdata : dm_addr;
                    wb_zero_d     = lat_zero_q;
                    wb_err_d      = 1'b0;
                end else if (timeout_c) begin
                    cnt_d      = '0;
                    dm_req_d   = 1'b0;
                    dm_we_d    = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = lat_rd_q;
                    wb_zero_d  = lat_zero_q;
                    wb_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q          <= '0;
            lat_rd_q       <= '0;
            lat_regwrite_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            lat_store_q    <= 1'b0;
            lat_zero_q     <= '0;
            dm_req         <= 1'b0;
            dm_we          <= 1'b0;
            dm_addr        <= '0;
            dm_wdata       <= '0;
            wb_valid       <= 1'b0;
            wb_regwrite    <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            wb_zero        <= '0;
            wb_err         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            lat_rd_q       <= lat_rd_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            lat_store_q    <= lat_store_d;
            lat_zero_q     <= lat_zero_d;
            dm_req         <= dm_req_d;
            dm_we          <= dm_we_d;
            dm_addr        <= dm_addr_d;
            dm_wdata       <= dm_wdata_d;
            wb_valid       <= wb_valid_d;
            wb_regwrite    <= wb_regwrite_d;
            wb_rd          <= wb_rd_d;
            wb_data        <= wb_data_d;
            wb_zero        <= wb_zero_d;
            wb_err         <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; expected values are hand-derived constants.
module tb_mem_wb_stage;

    localparam int unsigned S = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
    logic [S-1:0] mem_ALUout, mem_wdata;
    logic [1:0]   mem_zero;
    logic [4:0]   mem_rd;
    logic         dm_req, dm_we, dm_ack;
    logic [S-1:0] dm_addr, dm_wdata, dm_rdata;
    logic         stall, wb_valid, wb_regwrite, wb_err;
    logic [4:0]   wb_rd;
    logic [S-1:0] wb_data;
    logic [1:0]   wb_zero;

    int n_chk  = 0;
    int n_pass = 0;

    mem_wb_stage #(.S(S), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ALUout(mem_ALUout), .mem_zero(mem_zero),
        .mem_wdata(mem_wdata), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_zero(wb_zero), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd_op, input logic wr_op, input logic rw,
                         input logic m2r, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] wd);
        mem_valid    = v;
        mem_memread  = rd_op;
        mem_memwrite = wr_op;
        mem_regwrite = rw;
        mem_memtoreg = m2r;
        mem_rd       = rd;
        mem_ALUout   = addr;
        mem_wdata    = wd;
        mem_zero     = 2'b00;
    endtask

    initial begin
        reset    = 1'b0;
        dm_ack   = 1'b0;
        dm_rdata = '0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h100, 32'h0);

        // Reset held for three cycles with a load presented
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_dm_req", 32'(dm_req), 32'd0);
            chk("rst_wb_valid", 32'(wb_valid), 32'd0);
            chk("rst_stall", 32'(stall), 32'd0);
        end
        chk("rst_wb_data", wb_data, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();

        // ALU op: one-cycle latency, no stall
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h2A, 32'h0);
        mem_zero = 2'b01;
        @(negedge clk);
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_rd", 32'(wb_rd), 32'd5);
        chk("alu_wb_data", wb_data, 32'h2A);
        chk("alu_wb_regwrite", 32'(wb_regwrite), 32'd1);
        chk("alu_wb_zero", 32'(wb_zero), 32'd1);
        chk("alu_wb_err", 32'(wb_err), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        chk("bubble_wb_valid", 32'(wb_valid), 32'd0);
        chk("bubble_wb_rd_hold", 32'(wb_rd), 32'd5);

        // Load with ack in the fourth ACCESS cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h100, 32'h0);
        @(negedge clk);
        chk("ld_stall_issue", 32'(stall), 32'd1);
        tick();
        chk("ld_dm_req", 32'(dm_req), 32'd1);
        chk("ld_dm_we", 32'(dm_we), 32'd0);
        chk("ld_wb_valid_bubble", 32'(wb_valid), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("ld_stall_wait", 32'(stall), 32'd1);
            tick();
            chk("ld_dm_addr_stable", dm_addr, 32'h100);
            chk("ld_dm_req_hold", 32'(dm_req), 32'd1);
        end
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld_stall_ack", 32'(stall), 32'd0);
        tick();
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_regwrite", 32'(wb_regwrite), 32'd1);
        chk("ld_wb_rd", 32'(wb_rd), 32'd8);
        chk("ld_dm_req_drop", 32'(dm_req), 32'd0);
        dm_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();

        // Store with ack in the first ACCESS cycle
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h200, 32'h12345678);
        @(negedge clk);
        chk("st_stall_issue", 32'(stall), 32'd1);
        tick();
        chk("st_dm_we", 32'(dm_we), 32'd1);
        chk("st_dm_wdata", dm_wdata, 32'h12345678);
        chk("st_dm_addr", dm_addr, 32'h200);
        dm_ack = 1'b1;
        @(negedge clk);
        chk("st_stall_ack", 32'(stall), 32'd0);
        tick();
        chk("st_wb_valid", 32'(wb_valid), 32'd1);
        chk("st_wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("st_wb_data", wb_data, 32'h200);
        dm_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();

        // Load that never gets an ack: abandoned after 15 ACCESS cycles
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h300, 32'h0);
        tick();
        chk("to_dm_req", 32'(dm_req), 32'd1);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            chk("to_stall_wait", 32'(stall), 32'd1);
            tick();
            chk("to_dm_req_hold", 32'(dm_req), 32'd1);
        end
        @(negedge clk);
        chk("to_stall_last", 32'(stall), 32'd0);
        tick();
        chk("to_wb_err", 32'(wb_err), 32'd1);
        chk("to_wb_valid", 32'(wb_valid), 32'd1);
        chk("to_wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("to_dm_req_drop", 32'(dm_req), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        dm_ack = 1'b1;
        tick();
        chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        chk("late_ack_dm_req", 32'(dm_req), 32'd0);
        dm_ack = 1'b0;

        // Next ALU result clears the error flag
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h55, 32'h0);
        tick();
        chk("err_clear", 32'(wb_err), 32'd0);
        chk("err_clear_data", wb_data, 32'h55);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();

        // Reset pulse during ACCESS discards the access
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h400, 32'h0);
        tick();
        chk("rp_dm_req", 32'(dm_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rp_dm_req_async", 32'(dm_req), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        reset  = 1'b1;
        dm_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rp_wb_valid", 32'(wb_valid), 32'd0);
            chk("rp_dm_req", 32'(dm_req), 32'd0);
            dm_ack = 1'b0;
        end

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned load is rejected without a request
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h102, 32'h0);
        @(negedge clk);
        chk("al_stall", 32'(stall), 32'd0);
        tick();
        chk("al_dm_req", 32'(dm_req), 32'd0);
        chk("al_wb_valid", 32'(wb_valid), 32'd1);
        chk("al_wb_err", 32'(wb_err), 32'd1);
        chk("al_wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("al_wb_rd", 32'(wb_rd), 32'd12);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
